d_ff: RTL and testbench

//   Parameterised D-type register: captures d on each rising clk edge and

---
 rtl/d_ff_pkg.sv | 15 +
 rtl/d_ff_stage.sv | 26 ++
 rtl/d_ff.sv | 39 +++
 tb/tb_d_ff.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/d_ff_pkg.sv
// Shared limits and legality check for the d_ff register chain.
// Kept in one place so the top and any wrappers agree on the legal ranges.
package d_ff_pkg;

    localparam int WIDTH_MIN  = 1;
    localparam int WIDTH_MAX  = 1024;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 16;

    function automatic bit params_ok(input int width, input int stages);
        return (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
               (stages >= STAGES_MIN) && (stages <= STAGES_MAX);
    endfunction

endpackage

// File: rtl/d_ff_stage.sv
// One WIDTH-bit register with synchronous active-high reset.
// Powers up holding RESET_VAL, so the output is never X before the first edge.
module d_ff_stage #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Declaration initialiser doubles as the FPGA INIT value.
    logic [WIDTH-1:0] r_q = RESET_VAL;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= RESET_VAL;
        end else begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/d_ff.sv
// Parameterised D register: STAGES chained d_ff_stage cells, q taken from
// the last flop with no combinational path from d or rst.
module d_ff
    import d_ff_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               STAGES    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
        $fatal(1, "d_ff: WIDTH=%0d or STAGES=%0d out of range", WIDTH, STAGES);
    end

    // w_chain[0] is the input, w_chain[i+1] the output of stage i.
    logic [WIDTH-1:0] w_chain [STAGES+1];

    assign w_chain[0] = d;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        d_ff_stage #(
            .WIDTH    (WIDTH),
            .RESET_VAL(RESET_VAL)
        ) u_stage (
            .i_clk(clk),
            .i_rst(rst),
            .i_d  (w_chain[g]),
            .o_q  (w_chain[g+1])
        );
    end

    assign q = w_chain[STAGES];

endmodule

// File: tb/tb_d_ff.sv
// Bench for d_ff: a 1-bit single-stage instance and an 8-bit three-stage
// instance, checked against an edge-history model of the register.
module tb_d_ff;

    localparam int         S2  = 3;
    localparam logic [7:0] RV2 = 8'hA5;

    logic       clk = 1'b0;
    logic       rst1 = 1'b1;
    logic [0:0] d1 = 1'b0;
    logic [0:0] q1;
    logic       rst2 = 1'b1;
    logic [7:0] d2 = 8'h00;
    logic [7:0] q2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit         r;
        logic [7:0] d;
    } hent_t;

    // Per-edge history of what each DUT saw; oldest entry first.
    hent_t h1[$];
    hent_t h2[$];

    d_ff #(.WIDTH(1), .RESET_VAL(1'b0), .STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst1), .d(d1), .q(q1)
    );

    d_ff #(.WIDTH(8), .RESET_VAL(RV2), .STAGES(S2)) u_dut2 (
        .clk(clk), .rst(rst2), .d(d2), .q(q2)
    );

    initial begin
        #5;
        forever #5 clk = ~clk;
    end

    // q after an edge is RESET_VAL if any of the last `stages` edges saw reset,
    // otherwise the d sampled `stages` edges ago (power-on counts as reset).
    function automatic logic [7:0] model(input hent_t h[$], input int stages,
                                         input logic [7:0] rv);
        for (int i = 0; i < stages; i++)
            if (h[h.size()-1-i].r) return rv;
        return h[h.size()-stages].d;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick(input string tag);
        hent_t e;
        @(posedge clk);
        e.r = rst1; e.d = {7'b0, d1}; h1.push_back(e);
        e.r = rst2; e.d = d2;         h2.push_back(e);
        while (h1.size() > 1)  void'(h1.pop_front());
        while (h2.size() > S2) void'(h2.pop_front());
        #1;
        chk({tag, "_q1"}, {7'b0, q1}, model(h1, 1, 8'h00));
        chk({tag, "_q2"}, q2, model(h2, S2, RV2));
    endtask

    initial begin
        hent_t pw;
        pw.r = 1'b1; pw.d = 8'h00;
        h1.push_back(pw);
        for (int i = 0; i < S2; i++) h2.push_back(pw);

        // power-on: never X before the first edge
        #1;
        chk("poweron_q1", {7'b0, q1}, 8'h00);
        chk("poweron_q2", q2, RV2);

        // reset overrides d
        d1 = 1'b1; d2 = 8'hFF;
        tick("rst_prio");
        tick("rst_prio");
        chk("rst_prio_abs", {7'b0, q1}, 8'h00);

        // capture: 0,1,0 each held two cycles
        rst1 = 1'b0;
        d1 = 1'b0; tick("cap0"); tick("cap0");
        d1 = 1'b1; tick("cap1"); tick("cap1");
        chk("cap1_abs", {7'b0, q1}, 8'h01);
        d1 = 1'b0; tick("cap2"); tick("cap2");

        // random data
        for (int i = 0; i < 8; i++) begin
            d1 = 1'($urandom);
            tick("rand1");
        end

        // reset mid-run
        d1 = 1'b1; tick("mid_pre");
        rst1 = 1'b1;
        #8;
        chk("mid_before_edge", {7'b0, q1}, 8'h01);
        tick("mid_rst");
        chk("mid_rst_abs", {7'b0, q1}, 8'h00);
        rst1 = 1'b0;
        tick("mid_rel");
        chk("mid_rel_abs", q1 === 1'b1 ? 8'h01 : 8'h00, 8'h01);

        // three-stage sweep: RESET_VAL drains over two edges, then 3C
        d2 = 8'h3C; rst2 = 1'b0;
        tick("sweep1"); chk("sweep1_abs", q2, 8'hA5);
        tick("sweep2"); chk("sweep2_abs", q2, 8'hA5);
        tick("sweep3"); chk("sweep3_abs", q2, 8'h3C);
        tick("sweep4"); chk("sweep4_abs", q2, 8'h3C);

        // d wiggling between edges must not reach q
        d2 = 8'h11; #3; d2 = 8'h22; #3;
        chk("no_transp", q2, 8'h3C);
        d2 = 8'h33;
        tick("wiggle");

        // random data and occasional reset on both instances
        for (int i = 0; i < 60; i++) begin
            d1   = 1'($urandom);
            d2   = 8'($urandom);
            rst1 = ($urandom_range(0, 7) == 0);
            rst2 = ($urandom_range(0, 9) == 0);
            tick("rand_mix");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL timeout t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
